oled_frame_buffer: RTL

- Double-buffered 96x64 RGB565 frame store that answers the OLED driver's pixel request interface (pixel_index in, pixel_data out).
- It decouples the sprite/background/status-bar renderer from the OLED scan.
- The renderer writes a complete frame into the back bank while the driver reads the front bank.
- Banks swap only at a frame boundary (frame_begin), so the display never tears.

---
 rtl/oled_frame_buffer_pkg.sv | 19 +
 rtl/fb_bank.sv | 35 +++
 rtl/oled_frame_buffer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/oled_frame_buffer_pkg.sv
// Shared definitions for the OLED frame buffer.
// Holds the panel geometry, the default clear colour and the controller
// state encoding used by oled_frame_buffer and its bank RAMs.
package oled_frame_buffer_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_NPIX   = OLED_WIDTH * OLED_HEIGHT;

  localparam logic [15:0] COL_BLACK = 16'h0000;

  typedef enum logic [1:0] {
    CLEAR_ALL  = 2'd0,
    CLEAR_BACK = 2'd1,
    RENDER     = 2'd2,
    WAIT_SWAP  = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM with one synchronous write port and
// one registered read port, shaped for block-RAM inference.
// Ports:
//   clk     - clock
//   wr_en   - write strobe
//   wr_addr - write address (caller keeps it below DEPTH)
//   wr_data - write data
//   rd_addr - read address (caller keeps it below DEPTH)
//   rd_data - registered read data, one cycle after rd_addr
module fb_bank
  import oled_frame_buffer_pkg::*;
#(
  parameter int DEPTH  = OLED_NPIX,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // No reset on the array or the read register so the tools map it to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/oled_frame_buffer.sv
// Double-buffered RGB565 frame store between the renderer and the OLED scan.
// The renderer fills the back bank; the driver reads the front bank; the
// banks swap only on frame_begin after the renderer reports a full frame.
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   wr_en/wr_index/wr_colour, wr_ready - renderer write port
//   render_done, swap_pending          - frame handshake with the renderer
//   frame_begin                        - start-of-scan from the OLED driver
//   pixel_index -> pixel_data          - read port, one cycle latency
//   front_sel, frame_count             - displayed bank, completed swaps
module oled_frame_buffer
  import oled_frame_buffer_pkg::*;
#(
  parameter int               WIDTH        = OLED_WIDTH,
  parameter int               HEIGHT       = OLED_HEIGHT,
  parameter int               IDX_W        = 13,
  parameter int               COL_W        = 16,
  parameter logic [COL_W-1:0] CLEAR_COLOUR = COL_BLACK
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [COL_W-1:0] wr_colour,
  output logic             wr_ready,
  input  logic             render_done,
  output logic             swap_pending,
  input  logic             frame_begin,
  input  logic [IDX_W-1:0] pixel_index,
  output logic [COL_W-1:0] pixel_data,
  output logic             front_sel,
  output logic [7:0]       frame_count
);

  localparam int               NPIX     = WIDTH * HEIGHT;
  localparam logic [IDX_W:0]   NPIX_EXT = (IDX_W+1)'(NPIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  fb_state_e        state_reg, state_next;
  logic [IDX_W-1:0] ctr_reg, ctr_next;
  logic             front_sel_reg, front_sel_next;
  logic [7:0]       frame_count_reg, frame_count_next;

  logic [1:0]       bank_we;
  logic [IDX_W-1:0] bank_waddr;
  logic [COL_W-1:0] bank_wdata;
  logic [COL_W-1:0] bank_rdata [2];

  logic             rd_bank_reg, rd_force_reg;
  logic             swap_now, rd_in_range;
  logic [IDX_W-1:0] rd_addr;

  // One-hot enable for the bank that is not being displayed.
  logic [1:0]       back_mask;
  assign back_mask = front_sel_reg ? 2'b01 : 2'b10;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= CLEAR_ALL;
      ctr_reg         <= '0;
      front_sel_reg   <= 1'b0;
      frame_count_reg <= '0;
      rd_bank_reg     <= 1'b0;
      rd_force_reg    <= 1'b1;
    end else begin
      state_reg       <= state_next;
      ctr_reg         <= ctr_next;
      front_sel_reg   <= front_sel_next;
      frame_count_reg <= frame_count_next;
      rd_bank_reg     <= front_sel_reg ^ swap_now;
      rd_force_reg    <= !rd_in_range || (state_reg == CLEAR_ALL);
    end
  end

  always_comb begin
    state_next       = state_reg;
    ctr_next         = ctr_reg;
    front_sel_next   = front_sel_reg;
    frame_count_next = frame_count_reg;
    bank_we          = 2'b00;
    bank_waddr       = ctr_reg;
    bank_wdata       = CLEAR_COLOUR;

    case (state_reg)
      CLEAR_ALL, CLEAR_BACK: begin
        bank_we = (state_reg == CLEAR_ALL) ? 2'b11 : back_mask;
        // Counter parks on the last pixel rather than wrapping out of range.
        if (ctr_reg == LAST_IDX) begin
          state_next = RENDER;
        end else begin
          ctr_next = ctr_reg + 1'b1;
        end
      end
      RENDER: begin
        if (wr_en && ({1'b0, wr_index} < NPIX_EXT)) begin
          bank_we    = back_mask;
          bank_waddr = wr_index;
          bank_wdata = wr_colour;
        end
        if (render_done) begin
          state_next = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (frame_begin) begin
          // The old front becomes the back bank and is cleared next.
          front_sel_next   = !front_sel_reg;
          frame_count_next = frame_count_reg + 8'd1;
          ctr_next         = '0;
          state_next       = CLEAR_BACK;
        end
      end
      default: state_next = CLEAR_ALL;
    endcase
  end

  // The read in the swap cycle already targets the incoming frame.
  assign swap_now    = (state_reg == WAIT_SWAP) && frame_begin;
  assign rd_in_range = {1'b0, pixel_index} < NPIX_EXT;
  assign rd_addr     = rd_in_range ? pixel_index : '0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      fb_bank #(
        .DEPTH  (NPIX),
        .ADDR_W (IDX_W),
        .DATA_W (COL_W)
      ) u_bank (
        .clk     (clk),
        .wr_en   (bank_we[gi]),
        .wr_addr (bank_waddr),
        .wr_data (bank_wdata),
        .rd_addr (rd_addr),
        .rd_data (bank_rdata[gi])
      );
    end
  endgenerate

  assign pixel_data   = rd_force_reg ? CLEAR_COLOUR : bank_rdata[rd_bank_reg];
  assign wr_ready     = (state_reg == RENDER);
  assign swap_pending = (state_reg == WAIT_SWAP);
  assign front_sel    = front_sel_reg;
  assign frame_count  = frame_count_reg;

endmodule
